// File: rtl/mult_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult_share_arbiter                                           |
// | Description : Round-robin sharing of one N x N signed multiplier between   |
// |               two requesters; latches operands, pulses init, captures p.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module mult_share_arbiter #(
    parameter int N       = 4,
    parameter int MUL_LAT = 2*N+4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [N-1:0]     a0,
    input  logic [N-1:0]     b0,
    output logic             ack0,
    output logic [2*N-1:0]   y0,
    input  logic             req1,
    input  logic [N-1:0]     a1,
    input  logic [N-1:0]     b1,
    output logic             ack1,
    output logic [2*N-1:0]   y1,
    output logic             mult_init,
    output logic [N-1:0]     mult_a,
    output logic [N-1:0]     mult_b,
    input  logic [2*N-1:0]   mult_p,
    output logic             busy,
    output logic             grant
);

    localparam int                 c_CNT_W    = $clog2(MUL_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_last;
    logic                 r_grant;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [N-1:0]         r_mult_a;
    logic [N-1:0]         r_mult_b;
    logic [2*N-1:0]       r_y0;
    logic [2*N-1:0]       r_y1;
    logic                 w_any_req;
    logic                 w_winner;

    assign w_any_req = req0 | req1;
    // On contention the port that was not served last wins.
    assign w_winner  = (req0 & req1) ? ~r_last : req1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_LOAD;
            S_LOAD:  w_next = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last   <= 1'b1;
            r_grant  <= 1'b0;
            r_cnt    <= '0;
            r_mult_a <= '0;
            r_mult_b <= '0;
            r_y0     <= '0;
            r_y1     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant  <= w_winner;
                        r_mult_a <= w_winner ? a1 : a0;
                        r_mult_b <= w_winner ? b1 : b0;
                    end
                end
                S_LOAD: r_cnt <= c_CNT_LOAD;
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_grant) r_y1 <= mult_p;
                        else         r_y0 <= mult_p;
                        r_last <= r_grant;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mult_init = (r_state == S_LOAD);
    assign busy      = (r_state != S_IDLE);
    assign ack0      = (r_state == S_DONE) && !r_grant;
    assign ack1      = (r_state == S_DONE) &&  r_grant;
    assign grant     = r_grant;
    assign mult_a    = r_mult_a;
    assign mult_b    = r_mult_b;
    assign y0        = r_y0;
    assign y1        = r_y1;

endmodule
`default_nettype wire

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Two-port round-robin scheduler that shares one Booth multiplier (`module_multiplicador`, signed N×N → 2N) between two requesters. The block owns the multiplier's `init`, `a` and `b` inputs. It latches the operands of the granted requester, pulses `init`, and waits a fixed latency. It then captures `p` into that requester's result register and acknowledges. It sits between the multiplier instance and the client logic that previously drove the multiplier directly.

## Interface
- `N`, 4, operand width; must equal the multiplier's `N`.
- `MUL_LAT`, 2*N+4, number of clock edges after the edge that samples `mult_init`=1 until `mult_p` is valid and stable. Must be ≥1 and must match the multiplier configuration.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0` in 1: requester 0 request (level).
- `a0`, `b0` in N: requester 0 signed operands; sampled only at grant.
- `ack0` out 1: one-cycle pulse; `y0` is valid while it is high.
- `y0` out 2N: requester 0 product register; holds its value until the next ack0.
- `req1`, `a1`, `b1`, `ack1`, `y1`: same as requester 0, for port 1.
- `mult_init` out 1: start pulse to the multiplier.
- `mult_a`, `mult_b` out N: registered operands to the multiplier.
- `mult_p` in 2N: multiplier product.
- `busy` out 1: high in any state other than IDLE.
- `grant` out 1: index of the requester currently being served; holds the last winner when idle.

## Operation
- FSM states: IDLE, LOAD, WAIT, DONE.
- **IDLE**
  - With no request, stay in IDLE.
  - With any `reqk`, choose a winner, latch `ak`/`bk` into `mult_a`/`mult_b`, set `grant`=k, and go to LOAD.
- **Arbitration**
  - Round-robin using `last` (reset value 1).
  - If both requests are high, the requester ≠ `last` wins.
  - If one request is high, it wins.
  - `last` updates on entering DONE.
- **LOAD**: `mult_init`=1 for exactly this cycle. Load the wait counter with MUL_LAT−1. Go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - On the edge where the counter is 0, capture `mult_p` into `y[grant]` and go to DONE.
  - WAIT therefore lasts exactly MUL_LAT cycles.
- **DONE**: `ack[grant]`=1 for this cycle only; then return to IDLE.
- **Handshake**
  - The requester holds `reqk` and its operands until IDLE samples them.
  - The requester must drop `reqk` on the edge after `ackk` unless it wants another product.
  - A `reqk` still high in the following IDLE cycle is a new request.
- **Operand stability**: `mult_a`/`mult_b` change only on the IDLE→LOAD edge. Operand changes on `ak`/`bk` after grant have no effect.
- **Arithmetic**: `y` is the multiplier's 2N-bit signed product. The block passes it through unmodified and does no sign handling of its own.

## Timing
- Reset (async, `rst`=0) values:
  - state=IDLE
  - `mult_init`=0, `mult_a`=`mult_b`=0
  - `ack0`=`ack1`=0, `y0`=`y1`=0
  - `busy`=0, `grant`=0, `last`=1, counter=0
- Reset mid-operation aborts the job immediately:
  - No ack is issued and `y` registers clear.
  - The requester must re-request after reset release.
- Request seen in IDLE at cycle t:
  - LOAD at t+1
  - WAIT from t+2 to t+1+MUL_LAT
  - DONE/ack at t+2+MUL_LAT
  - IDLE at t+3+MUL_LAT
- Service time is MUL_LAT+3 cycles per job. Back-to-back jobs have no extra gap: IDLE→LOAD occurs in the first IDLE cycle.
- Both requesters held high: service alternates 0,1,0,1… Worst-case wait for a requester is 2·(MUL_LAT+3) cycles.
- `ack0` and `ack1` are never high in the same cycle. At most one `mult_init` pulse occurs per job.
- Requests arriving while `busy` are ignored until IDLE. They are neither queued nor lost, because the level is still present.

## Test plan
- Single request (N=4, MUL_LAT=12): `req0` with `a0`=3, `b0`=−2 → `mult_init` pulses one cycle at t+1; `ack0` at t+14; `y0`=8'hFA; `ack1` never asserts.
- Simultaneous requests from reset: `req0`/`req1` high at the same cycle with (5,5) and (−8,7) → port 0 is served first (`y0`=8'h19), then port 1 (`y1`=8'hC8). The two acks are MUL_LAT+3 cycles apart.
- Fairness: both requests held high for 6 jobs → grant sequence 0,1,0,1,0,1, with exactly 3 acks per port.
- Operand change after grant: change `a1` from 2 to 7 during WAIT with `b1`=3 → `y1`=8'h06, and `mult_a` stays 2 throughout.
- Reset mid-WAIT: assert `rst`=0 for 1 cycle → all outputs return to reset values asynchronously; no ack is issued. A re-request after release completes normally.
- Extremes: `a`=−8, `b`=−8 → `y`=8'h40. `a`=7, `b`=−8 → `y`=8'hC8.
